div_ctrl: RTL and testbench

Multi-cycle sequencer for RV32M divide/remainder (DIV, DIVU, REM, REMU) alongside the single-cycle execute stage. It accepts one operation from execute, and holds the pipeline through `busy_o` while a 32-iteration restoring divider runs. It then returns the result with its destination register address and write enable for one cycle. One operation is in flight at a time, and a pipeline flush cancels it.

---
 rtl/div_ctrl.sv | 147 ++++++++++++++
 tb/tb_div_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle RV32M divide/remainder sequencer (restoring, one bit per cycle)
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_wen_o
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] dvsr_mag;
  logic [CNT_W-1:0]  cnt;
  logic              q_neg;
  logic              r_neg;

  logic              is_signed;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              div_zero;
  logic              sgn_ovf;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;
  logic              fits;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quot_nxt;
  logic              last;
  logic              ready;

  // op bit 0 set means unsigned (DIVU/REMU); bit 1 set selects the remainder
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & dividend_q[DATA_W-1];
  assign b_neg     = is_signed & divisor_q[DATA_W-1];
  assign a_mag     = a_neg ? -dividend_q : dividend_q;
  assign b_mag     = b_neg ? -divisor_q : divisor_q;
  assign div_zero  = (divisor_q == '0);
  assign sgn_ovf   = is_signed && (dividend_q == {1'b1, {(DATA_W-1){1'b0}}}) && (divisor_q == '1);

  // One extra bit on the trial subtraction so the borrow reads out as the sign
  assign rem_sh   = {rem, quot[DATA_W-1]};
  assign diff     = rem_sh - {1'b0, dvsr_mag};
  assign fits     = ~diff[DATA_W];
  assign rem_nxt  = fits ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign quot_nxt = {quot[DATA_W-2:0], fits};
  assign last     = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_q       <= '0;
      rem        <= '0;
      quot       <= '0;
      dvsr_mag   <= '0;
      cnt        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q       <= op_i;
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            rd_q       <= rd_addr_i;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else if (div_zero) begin
            quot  <= '1;
            rem   <= dividend_q;
            state <= S_END;
          end else if (sgn_ovf) begin
            quot  <= {1'b1, {(DATA_W-1){1'b0}}};
            rem   <= '0;
            state <= S_END;
          end else begin
            // quot doubles as the dividend shift register, emptied MSB first
            quot     <= a_mag;
            rem      <= '0;
            dvsr_mag <= b_mag;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            cnt      <= '0;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              quot  <= q_neg ? -quot_nxt : quot_nxt;
              rem   <= r_neg ? -rem_nxt : rem_nxt;
              state <= S_END;
            end else begin
              quot <= quot_nxt;
              rem  <= rem_nxt;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush landing on the END cycle suppresses the writeback
  assign ready     = (state == S_END) && !flush_i;
  assign busy_o    = (state == S_CHECK) || (state == S_CALC);
  assign ready_o   = ready;
  assign rd_wen_o  = ready;
  assign result_o  = ready ? (op_q[1] ? rem : quot) : '0;
  assign rd_addr_o = ready ? rd_q : 5'd0;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl
module tb_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        busy;
  logic        ready;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;
  logic        rd_wen;

  int errors = 0;
  int checks = 0;

  div_ctrl #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .rd_addr_i  (rd_addr),
    .flush_i    (flush),
    .busy_o     (busy),
    .ready_o    (ready),
    .result_o   (result),
    .rd_addr_o  (rd_addr_out),
    .rd_wen_o   (rd_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle k is the k-th clock period after the start edge E0; outputs are sampled
  // at its falling edge, flush/stray start are held across the rising edge that ends it.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                       input int exp_lat, input int flush_at, input int start_at);
    int          rdy_cnt;
    int          rdy_at;
    int          busy_cnt;
    int          spurious;
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        busy_post;
    rdy_cnt   = 0;
    rdy_at    = -1;
    busy_cnt  = 0;
    spurious  = 0;
    res       = '0;
    rdo       = '0;
    busy_post = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    rd_addr  = rd;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start = (k == start_at);
      flush = (k == flush_at);
      if (k == start_at) begin
        op       = 2'b01;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'd1;
        rd_addr  = 5'd9;
      end
      @(negedge clk);
      if (ready) begin
        rdy_cnt++;
        rdy_at = k;
        res    = result;
        rdo    = rd_addr_out;
      end else if (result !== 32'd0 || rd_addr_out !== 5'd0) begin
        spurious++;
      end
      if (rd_wen !== ready) spurious++;
      if (busy) busy_cnt++;
      if (k == flush_at + 1) busy_post = busy;
    end
    start = 1'b0;
    flush = 1'b0;
    chk({tag, "/stray_outputs"}, spurious, 0);
    if (exp_lat > 0) begin
      chk({tag, "/ready_pulses"}, rdy_cnt, 1);
      chk({tag, "/latency"}, rdy_at, exp_lat);
      chk({tag, "/result"}, res, exp_res);
      chk({tag, "/rd_addr"}, 32'(rdo), 32'(rd));
      chk({tag, "/busy_cycles"}, busy_cnt, exp_lat - 1);
    end else begin
      chk({tag, "/ready_pulses"}, rdy_cnt, 0);
      chk({tag, "/busy_after_flush"}, 32'(busy_post), 0);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/busy"}, 32'(busy), 0);
    chk({tag, "/ready"}, 32'(ready), 0);
    chk({tag, "/result"}, result, 0);
    chk({tag, "/rd_addr"}, 32'(rd_addr_out), 0);
    chk({tag, "/rd_wen"}, 32'(rd_wen), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    rd_addr  = '0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op("divu_100_7",  2'b01, 32'd100,        32'd7,          5'd5,  32'd14,         34, 0, 0);
    do_op("remu_100_7",  2'b11, 32'd100,        32'd7,          5'd6,  32'd2,          34, 0, 0);
    do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  34, 0, 0);
    do_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  34, 0, 0);
    do_op("div_7_m2",    2'b00, 32'd7,          32'hFFFF_FFFE,  5'd0,  32'hFFFF_FFFD,  34, 0, 0);
    do_op("divu_big",    2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd2,  32'd0,          34, 0, 0);
    do_op("div_by_zero", 2'b00, 32'd1234,       32'd0,          5'd10, 32'hFFFF_FFFF,  2,  0, 0);
    do_op("remu_by_zero",2'b11, 32'd1234,       32'd0,          5'd11, 32'd1234,       2,  0, 0);
    do_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  2,  0, 0);
    do_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          2,  0, 0);

    do_op("flush_calc",  2'b01, 32'd50,         32'd5,          5'd3,  32'd0,          0, 12, 0);
    do_op("after_flush", 2'b01, 32'd9,          32'd3,          5'd4,  32'd3,          34, 0, 0);
    do_op("flush_end",   2'b01, 32'd20,         32'd4,          5'd14, 32'd0,          0, 34, 0);
    do_op("stray_start", 2'b01, 32'd1000,       32'd3,          5'd15, 32'd333,        34, 0, 5);

    // Reset dropped mid-CALC
    @(negedge clk);
    start    = 1'b1;
    op       = 2'b01;
    dividend = 32'd1000;
    divisor  = 32'd3;
    rd_addr  = 5'd16;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_reset/busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("after_reset");
    do_op("divu_max_1",  2'b01, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  34, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
